alu_wb_buf: RTL and testbench

//  Writeback buffer between the ALU and the register file write port. It queues ALU results
//  (rd_idx, rd_wen, wdat) in a small in-order FIFO and drains them to the single regfile port.
//  The LSU has priority on that port, and a younger LSU write kills any queued ALU write to
//  the same register. The block also forwards pending results to operand read for RAW bypass.

---
 rtl/alu_wb_buf_if.sv | 46 ++++
 rtl/alu_wb_buf.sv | 122 ++++++++++++
 tb/tb_alu_wb_buf.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_buf_if.sv
// Bundle of the ALU result, LSU write, regfile port, forwarding and status signals of
// alu_wb_buf.
//  master: drives the ALU/LSU/lookup inputs and observes the outputs (pipeline side).
//  slave : the writeback buffer itself.
interface alu_wb_buf_if #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RIDX  = 5
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            i_alu_vld;
  logic            o_alu_rdy;
  logic [RIDX-1:0] i_alu_rd_idx;
  logic            i_alu_rd_wen;
  logic [XLEN-1:0] i_alu_wdat;
  logic            i_lsu_wen;
  logic [RIDX-1:0] i_lsu_rd_idx;
  logic [XLEN-1:0] i_lsu_wdat;
  logic            o_rf_wen;
  logic [RIDX-1:0] o_rf_widx;
  logic [XLEN-1:0] o_rf_wdat;
  logic [RIDX-1:0] i_fwd_rs1_idx;
  logic            o_fwd_rs1_hit;
  logic [XLEN-1:0] o_fwd_rs1_dat;
  logic [RIDX-1:0] i_fwd_rs2_idx;
  logic            o_fwd_rs2_hit;
  logic [XLEN-1:0] o_fwd_rs2_dat;
  logic [CW-1:0]   o_cnt;

  modport master (
    output i_alu_vld, i_alu_rd_idx, i_alu_rd_wen, i_alu_wdat,
    output i_lsu_wen, i_lsu_rd_idx, i_lsu_wdat,
    output i_fwd_rs1_idx, i_fwd_rs2_idx,
    input  o_alu_rdy, o_rf_wen, o_rf_widx, o_rf_wdat,
    input  o_fwd_rs1_hit, o_fwd_rs1_dat, o_fwd_rs2_hit, o_fwd_rs2_dat, o_cnt
  );

  modport slave (
    input  i_alu_vld, i_alu_rd_idx, i_alu_rd_wen, i_alu_wdat,
    input  i_lsu_wen, i_lsu_rd_idx, i_lsu_wdat,
    input  i_fwd_rs1_idx, i_fwd_rs2_idx,
    output o_alu_rdy, o_rf_wen, o_rf_widx, o_rf_wdat,
    output o_fwd_rs1_hit, o_fwd_rs1_dat, o_fwd_rs2_hit, o_fwd_rs2_dat, o_cnt
  );
endinterface

// File: rtl/alu_wb_buf.sv
// Writeback buffer between the ALU and the single regfile write port. ALU results are
// queued in order and drained when the LSU does not claim the port; an LSU write kills
// queued ALU writes to the same register. Pending live results are forwarded to two
// operand lookups (youngest wins).
// Ports:
//  clk  clock, rising edge
//  rst  asynchronous reset, active-high
//  bus  alu_wb_buf_if.slave: ALU in/ready, LSU in, regfile port out, rs1/rs2 forwarding,
//       occupancy count
module alu_wb_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RIDX  = 5
) (
  input logic         clk,
  input logic         rst,
  alu_wb_buf_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [RIDX-1:0] idx_q [DEPTH];
  logic [XLEN-1:0] dat_q [DEPTH];

  logic rdy, empty, push, pop, kill;
  logic [PW-1:0] slot;

  // Ready ignores a same-cycle pop so the LSU never reaches ready combinationally.
  assign rdy   = !rst && (cnt_q < CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = bus.i_alu_vld && rdy && bus.i_alu_rd_wen && (bus.i_alu_rd_idx != '0);
  assign pop   = !bus.i_lsu_wen && !empty;
  assign kill  = bus.i_lsu_wen && (bus.i_lsu_rd_idx != '0);

  assign bus.o_alu_rdy = rdy;
  assign bus.o_cnt     = cnt_q;

  // Port mux. State is already cleared during reset; only the LSU path needs gating.
  always_comb begin
    bus.o_rf_wen  = 1'b0;
    bus.o_rf_widx = '0;
    bus.o_rf_wdat = '0;
    if (!rst) begin
      if (bus.i_lsu_wen) begin
        if (bus.i_lsu_rd_idx != '0) begin
          bus.o_rf_wen  = 1'b1;
          bus.o_rf_widx = bus.i_lsu_rd_idx;
          bus.o_rf_wdat = bus.i_lsu_wdat;
        end
      end else if (!empty && live_q[rd_ptr_q]) begin
        bus.o_rf_wen  = 1'b1;
        bus.o_rf_widx = idx_q[rd_ptr_q];
        bus.o_rf_wdat = dat_q[rd_ptr_q];
      end
    end
  end

  // Forwarding: walk oldest to youngest so the last match is the youngest. Free and
  // killed slots have live=0, so no occupancy check is needed.
  always_comb begin
    bus.o_fwd_rs1_hit = 1'b0;
    bus.o_fwd_rs1_dat = '0;
    bus.o_fwd_rs2_hit = 1'b0;
    bus.o_fwd_rs2_dat = '0;
    slot              = rd_ptr_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PW'(k);
      if (live_q[slot] && (bus.i_fwd_rs1_idx != '0) && (idx_q[slot] == bus.i_fwd_rs1_idx)) begin
        bus.o_fwd_rs1_hit = 1'b1;
        bus.o_fwd_rs1_dat = dat_q[slot];
      end
      if (live_q[slot] && (bus.i_fwd_rs2_idx != '0) && (idx_q[slot] == bus.i_fwd_rs2_idx)) begin
        bus.o_fwd_rs2_hit = 1'b1;
        bus.o_fwd_rs2_dat = dat_q[slot];
      end
    end
  end

  // Next state: kill, then pop, then push (the entry accepted now is never killed).
  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill && (idx_q[i] == bus.i_lsu_rd_idx)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      live_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      live_q   <= live_d;
    end
  end

  // Payload needs no reset: it is only observed through live bits.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[wr_ptr_q] <= bus.i_alu_rd_idx;
      dat_q[wr_ptr_q] <= bus.i_alu_wdat;
    end
  end
endmodule

// File: tb/tb_alu_wb_buf.sv
module tb_alu_wb_buf;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RIDX  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_wb_buf_if #(.DEPTH(DEPTH), .XLEN(XLEN), .RIDX(RIDX)) bus ();

  alu_wb_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .RIDX(RIDX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        vld;
    logic        wen;
    logic [4:0]  idx;
    logic [31:0] dat;
    logic        lwen;
    logic [4:0]  lidx;
    logic [31:0] ldat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_rdy;
    logic        e_wen;
    logic [4:0]  e_widx;
    logic [31:0] e_wdat;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
    logic [1:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
    logic        live;
  } ent_t;

  vec_t tbl[18];
  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic wen, input logic [4:0] idx,
                       input logic [31:0] dat, input logic lwen, input logic [4:0] lidx,
                       input logic [31:0] ldat, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.i_alu_vld     = vld;
    bus.i_alu_rd_wen  = wen;
    bus.i_alu_rd_idx  = idx;
    bus.i_alu_wdat    = dat;
    bus.i_lsu_wen     = lwen;
    bus.i_lsu_rd_idx  = lidx;
    bus.i_lsu_wdat    = ldat;
    bus.i_fwd_rs1_idx = rs1;
    bus.i_fwd_rs2_idx = rs2;
  endtask

  task automatic check_out(input string tag, input logic erdy, input logic ewen,
                           input logic [4:0] ewidx, input logic [31:0] ewdat,
                           input logic eh1, input logic [31:0] ed1,
                           input logic eh2, input logic [31:0] ed2, input logic [1:0] ecnt);
    chk({tag, ".rdy"},  32'(bus.o_alu_rdy),     32'(erdy));
    chk({tag, ".wen"},  32'(bus.o_rf_wen),      32'(ewen));
    chk({tag, ".widx"}, 32'(bus.o_rf_widx),     32'(ewidx));
    chk({tag, ".wdat"}, bus.o_rf_wdat,          ewdat);
    chk({tag, ".hit1"}, 32'(bus.o_fwd_rs1_hit), 32'(eh1));
    chk({tag, ".dat1"}, bus.o_fwd_rs1_dat,      ed1);
    chk({tag, ".hit2"}, 32'(bus.o_fwd_rs2_hit), 32'(eh2));
    chk({tag, ".dat2"}, bus.o_fwd_rs2_dat,      ed2);
    chk({tag, ".cnt"},  32'(bus.o_cnt),         32'(ecnt));
  endtask

  function automatic vec_t mk(
      input logic vld, input logic wen, input logic [4:0] idx, input logic [31:0] dat,
      input logic lwen, input logic [4:0] lidx, input logic [31:0] ldat,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic erdy, input logic ewen, input logic [4:0] ewidx, input logic [31:0] ewdat,
      input logic eh1, input logic [31:0] ed1, input logic eh2, input logic [31:0] ed2,
      input logic [1:0] ecnt);
    vec_t v;
    v.vld = vld; v.wen = wen; v.idx = idx; v.dat = dat;
    v.lwen = lwen; v.lidx = lidx; v.ldat = ldat; v.rs1 = rs1; v.rs2 = rs2;
    v.e_rdy = erdy; v.e_wen = ewen; v.e_widx = ewidx; v.e_wdat = ewdat;
    v.e_h1 = eh1; v.e_d1 = ed1; v.e_h2 = eh2; v.e_d2 = ed2; v.e_cnt = ecnt;
    return v;
  endfunction

  // Reference: in-order list of pending results; port and forwarding rules evaluated on it.
  task automatic model_check(input string tag);
    logic        erdy, ewen, eh1, eh2;
    logic [4:0]  ewidx;
    logic [31:0] ewdat, ed1, ed2;
    erdy = (mq.size() < DEPTH);
    ewen = 1'b0; ewidx = '0; ewdat = '0;
    if (bus.i_lsu_wen) begin
      if (bus.i_lsu_rd_idx != 0) begin
        ewen = 1'b1; ewidx = bus.i_lsu_rd_idx; ewdat = bus.i_lsu_wdat;
      end
    end else if (mq.size() > 0 && mq[0].live) begin
      ewen = 1'b1; ewidx = mq[0].idx; ewdat = mq[0].dat;
    end
    eh1 = 1'b0; ed1 = '0; eh2 = 1'b0; ed2 = '0;
    foreach (mq[i]) begin
      if (mq[i].live && bus.i_fwd_rs1_idx != 0 && mq[i].idx == bus.i_fwd_rs1_idx) begin
        eh1 = 1'b1; ed1 = mq[i].dat;
      end
      if (mq[i].live && bus.i_fwd_rs2_idx != 0 && mq[i].idx == bus.i_fwd_rs2_idx) begin
        eh2 = 1'b1; ed2 = mq[i].dat;
      end
    end
    check_out(tag, erdy, ewen, ewidx, ewdat, eh1, ed1, eh2, ed2, 2'(mq.size()));
  endtask

  task automatic model_step();
    bit acc;
    ent_t e;
    acc = bus.i_alu_vld && (mq.size() < DEPTH);
    if (bus.i_lsu_wen && bus.i_lsu_rd_idx != 0) begin
      foreach (mq[i]) if (mq[i].idx == bus.i_lsu_rd_idx) mq[i].live = 1'b0;
    end
    if (!bus.i_lsu_wen && mq.size() > 0) void'(mq.pop_front());
    if (acc && bus.i_alu_rd_wen && bus.i_alu_rd_idx != 0) begin
      e.idx = bus.i_alu_rd_idx; e.dat = bus.i_alu_wdat; e.live = 1'b1;
      mq.push_back(e);
    end
  endtask

  initial begin
    //         vld wen idx  dat           lwen lidx ldat   rs1 rs2 rdy wen widx wdat
    //         h1 d1            h2 d2        cnt
    tbl[0]  = mk(0, 0, 0, 0,            0, 0, 0,     5, 0,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[1]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,     5, 5,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[2]  = mk(0, 0, 0, 0,            0, 0, 0,     5, 6,  1, 1, 5, 32'hDEADBEEF,
                 1, 32'hDEADBEEF, 0, 0,        1);
    tbl[3]  = mk(0, 0, 0, 0,            0, 0, 0,     5, 5,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[4]  = mk(1, 1, 3, 1,            1, 9, 32'h99, 3, 9, 1, 1, 9, 32'h99,
                 0, 0,            0, 0,        0);
    tbl[5]  = mk(1, 1, 3, 2,            1, 9, 32'h99, 3, 9, 1, 1, 9, 32'h99,
                 1, 1,            0, 0,        1);
    tbl[6]  = mk(1, 1, 4, 32'h44,       1, 9, 32'h99, 3, 3, 0, 1, 9, 32'h99,
                 1, 2,            1, 2,        2);
    tbl[7]  = mk(0, 0, 0, 0,            0, 0, 0,     3, 4,  0, 1, 3, 1,
                 1, 2,            0, 0,        2);
    tbl[8]  = mk(0, 0, 0, 0,            0, 0, 0,     4, 3,  1, 1, 3, 2,
                 0, 0,            1, 2,        1);
    tbl[9]  = mk(0, 0, 0, 0,            0, 0, 0,     3, 3,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[10] = mk(1, 1, 7, 32'hAA,       0, 0, 0,     7, 7,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[11] = mk(0, 0, 0, 0,            1, 7, 32'h55, 7, 0, 1, 1, 7, 32'h55,
                 1, 32'hAA,       0, 0,        1);
    tbl[12] = mk(0, 0, 0, 0,            0, 0, 0,     7, 7,  1, 0, 0, 0,
                 0, 0,            0, 0,        1);
    tbl[13] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[14] = mk(1, 0, 6, 32'h66,       0, 0, 0,     6, 6,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[15] = mk(1, 1, 0, 32'h77,       0, 0, 0,     0, 0,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[16] = mk(0, 0, 0, 0,            1, 0, 32'h88, 0, 0, 1, 0, 0, 0,
                 0, 0,            0, 0,        0);
    tbl[17] = mk(0, 0, 0, 0,            0, 0, 0,     6, 0,  1, 0, 0, 0,
                 0, 0,            0, 0,        0);

    // Reset held with LSU active: everything must read 0.
    drive(1, 1, 5, 32'h1, 1, 4, 32'h44, 4, 5);
    #2;
    check_out("in_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].wen, tbl[i].idx, tbl[i].dat, tbl[i].lwen, tbl[i].lidx,
            tbl[i].ldat, tbl[i].rs1, tbl[i].rs2);
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_wen, tbl[i].e_widx,
                tbl[i].e_wdat, tbl[i].e_h1, tbl[i].e_d1, tbl[i].e_h2, tbl[i].e_d2,
                tbl[i].e_cnt);
    end

    // Two entries pending behind a busy LSU, then asynchronous reset mid-cycle.
    @(negedge clk);
    drive(1, 1, 10, 32'hA, 1, 12, 32'hC, 10, 11);
    @(negedge clk);
    drive(1, 1, 11, 32'hB, 1, 12, 32'hC, 10, 11);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 12, 32'hC, 10, 11);
    #1;
    check_out("pre_rst", 0, 1, 12, 32'hC, 1, 32'hA, 1, 32'hB, 2);
    #1;
    rst = 1'b1;
    #1;
    check_out("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 10, 11);
    #1;
    check_out("post_rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_out("post_rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the list model.
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
            5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      model_check($sformatf("rnd%0d", c));
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
